// File: rtl/sya_skew_feeder.sv
// Input-skew stage of the systolic array: turns one NUM-lane vector per accept into a
// diagonal wavefront (lane i delayed i advances), then drains and pulses Done at end of tile.
// Build option: SYA_SKEW_DRAIN_ZERO_EN zeroes lane data whenever a bubble/drain slot enters.
module sya_skew_feeder #(
    parameter int DW  = 8,
    parameter int NUM = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic              InLast,
    input  logic [NUM*DW-1:0] InData,
    input  logic              OutReady,
    output logic [NUM*DW-1:0] OutData,
    output logic [NUM-1:0]    OutEnable,
    output logic              Busy,
    output logic              Done
);

    localparam int CW = $clog2(NUM) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic [NUM-1:0] vld_q;
    logic          accept;

    // Handshake: a vector transfers on a rising edge where InValid && InReady. OutReady is the
    // array's advance permission; while it is low nothing moves and no enables leave the stage.
    assign InReady   = OutReady && (state_q != DRAIN);
    assign accept    = InValid && InReady;
    assign OutEnable = vld_q & {NUM{OutReady}};
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // Done is a single-cycle pulse even if the array stalls right after the drain.
            done_q <= 1'b0;
            if (OutReady) begin
                case (state_q)
                    IDLE, FEED: begin
                        if (accept) begin
                            if (InLast) begin
                                state_q <= DRAIN;
                                cnt_q   <= CW'(NUM - 1);
                            end else begin
                                state_q <= FEED;
                            end
                        end
                    end
                    DRAIN: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        logic [DW-1:0] d_sr [0:i];
        logic          v_sr [0:i];

        always_ff @(posedge Clk) begin
            if (Rst) begin
                for (int s = 0; s <= i; s++) begin
                    d_sr[s] <= '0;
                    v_sr[s] <= 1'b0;
                end
            end else if (OutReady) begin
                v_sr[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    v_sr[s] <= v_sr[s-1];
                end
`ifdef SYA_SKEW_DRAIN_ZERO_EN
                d_sr[0] <= accept ? InData[i*DW +: DW] : '0;
                for (int s = 1; s <= i; s++) begin
                    d_sr[s] <= d_sr[s-1];
                end
`else
                // Data only moves with a valid token; empty slots leave the registers untouched.
                if (accept) begin
                    d_sr[0] <= InData[i*DW +: DW];
                end
                for (int s = 1; s <= i; s++) begin
                    if (v_sr[s-1]) begin
                        d_sr[s] <= d_sr[s-1];
                    end
                end
`endif
            end
        end

        assign OutData[i*DW +: DW] = d_sr[i];
        assign vld_q[i]            = v_sr[i];
    end

endmodule

// File: tb/tb_sya_skew_feeder.sv
// Directed bench for sya_skew_feeder (DW=8, NUM=4): per-cycle stimulus/expectation rows,
// a per-lane expected-data queue, and a single summary line.
module tb_sya_skew_feeder;

    localparam int DW   = 8;
    localparam int NUM  = 4;
    localparam int MAXC = 12;

`ifdef SYA_SKEW_DRAIN_ZERO_EN
    localparam logic [31:0] TAIL_SINGLE = 32'h0000_0000;
    localparam logic [31:0] TAIL_B2B    = 32'h0000_0000;
`else
    localparam logic [31:0] TAIL_SINGLE = 32'h0403_0201;
    localparam logic [31:0] TAIL_B2B    = 32'h0303_0303;
`endif

    logic              Clk;
    logic              Rst;
    logic              InValid;
    logic              InReady;
    logic              InLast;
    logic [NUM*DW-1:0] InData;
    logic              OutReady;
    logic [NUM*DW-1:0] OutData;
    logic [NUM-1:0]    OutEnable;
    logic              Busy;
    logic              Done;

    sya_skew_feeder #(.DW(DW), .NUM(NUM)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .InValid   (InValid),
        .InReady   (InReady),
        .InLast    (InLast),
        .InData    (InData),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutEnable (OutEnable),
        .Busy      (Busy),
        .Done      (Done)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-cycle vector table (-1 in an expectation column means "not checked")
    logic        vin_t  [MAXC];
    logic        last_t [MAXC];
    logic [31:0] data_t [MAXC];
    logic        ordy_t [MAXC];
    logic        rst_t  [MAXC];
    int          en_t   [MAXC];
    int          done_t [MAXC];
    int          rdy_t  [MAXC];
    int          busy_t [MAXC];
    int          out_t  [MAXC];
    logic [31:0] mask_t [MAXC];

    // scoreboard: expected lane bytes in arrival order
    logic [DW-1:0] exp_q [NUM][$];

    task automatic clear_vec();
        for (int c = 0; c < MAXC; c++) begin
            vin_t[c] = 1'b0; last_t[c] = 1'b0; data_t[c] = '0; ordy_t[c] = 1'b1; rst_t[c] = 1'b0;
            en_t[c] = 0; done_t[c] = 0; rdy_t[c] = -1; busy_t[c] = -1; out_t[c] = -1;
            mask_t[c] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic set_row(input int c, input logic vin, input logic last, input logic [31:0] data,
                           input logic ordy, input logic rst, input int en, input int done,
                           input int rdy, input int busy, input int out);
        vin_t[c] = vin; last_t[c] = last; data_t[c] = data; ordy_t[c] = ordy; rst_t[c] = rst;
        en_t[c] = en; done_t[c] = done; rdy_t[c] = rdy; busy_t[c] = busy; out_t[c] = out;
    endtask

    // driver: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge
    task automatic run_vec(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge Clk);
            #1;
            InValid  = vin_t[c];
            InLast   = last_t[c];
            InData   = data_t[c];
            OutReady = ordy_t[c];
            Rst      = rst_t[c];
            @(negedge Clk);
            if (en_t[c] >= 0)   check($sformatf("%s_c%0d_en", tag, c), 32'(OutEnable), en_t[c]);
            if (done_t[c] >= 0) check($sformatf("%s_c%0d_done", tag, c), 32'(Done), done_t[c]);
            if (rdy_t[c] >= 0)  check($sformatf("%s_c%0d_rdy", tag, c), 32'(InReady), rdy_t[c]);
            if (busy_t[c] >= 0) check($sformatf("%s_c%0d_busy", tag, c), 32'(Busy), busy_t[c]);
            if (out_t[c] >= 0)
                check($sformatf("%s_c%0d_data", tag, c), OutData & mask_t[c], out_t[c]);
            for (int i = 0; i < NUM; i++) begin
                if (OutEnable[i]) begin
                    if (exp_q[i].size() == 0)
                        check($sformatf("%s_c%0d_spurious_l%0d", tag, c, i), 32'(OutEnable[i]), 0);
                    else
                        check($sformatf("%s_c%0d_lane%0d", tag, c, i), 32'(OutData[i*DW +: DW]),
                              32'(exp_q[i].pop_front()));
                end
            end
            if (rst_t[c]) begin
                for (int i = 0; i < NUM; i++) exp_q[i].delete();
            end else if (vin_t[c] && ordy_t[c] && rdy_t[c] == 1) begin
                for (int i = 0; i < NUM; i++) exp_q[i].push_back(data_t[c][i*DW +: DW]);
            end
        end
        for (int i = 0; i < NUM; i++)
            check($sformatf("%s_left_l%0d", tag, i), 32'(exp_q[i].size()), 0);
    endtask

    task automatic load_single();
        clear_vec();
        //       c  vin last data          ordy rst en  done rdy busy out
        set_row(0, 1, 1, 32'h0403_0201, 1, 0,  0, 0, 1,  0, -1);
        set_row(1, 0, 0, 32'h0,         1, 0,  1, 0, 0,  1, -1);
        set_row(2, 0, 0, 32'h0,         1, 0,  2, 0, 0,  1, -1);
        set_row(3, 0, 0, 32'h0,         1, 0,  4, 0, 0,  1, -1);
        set_row(4, 0, 0, 32'h0,         1, 0,  8, 0, 0,  1, -1);
        set_row(5, 0, 0, 32'h0,         1, 0,  0, 1, 1, -1, -1);
        set_row(6, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        set_row(7, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, int'(TAIL_SINGLE));
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b0; InLast = 1'b0; InData = '0; OutReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_data", OutData, 32'h0);
        check("rst_en", 32'(OutEnable), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_rdy", 32'(InReady), 1);
        @(posedge Clk);
        #1 OutReady = 1'b0;
        @(negedge Clk);
        check("rst_rdy_frozen", 32'(InReady), 0);

        load_single();
        run_vec("single", 8);

        clear_vec();
        set_row(0, 1, 0, 32'h0101_0101, 1, 0,  0, 0, 1,  0, -1);
        set_row(1, 1, 0, 32'h0202_0202, 1, 0,  1, 0, 1,  1, -1);
        set_row(2, 1, 1, 32'h0303_0303, 1, 0,  3, 0, 1,  1, -1);
        set_row(3, 0, 0, 32'h0,         1, 0,  7, 0, 0,  1, -1);
        set_row(4, 0, 0, 32'h0,         1, 0, 14, 0, 0,  1, -1);
        set_row(5, 0, 0, 32'h0,         1, 0, 12, 0, 0,  1, -1);
        set_row(6, 0, 0, 32'h0,         1, 0,  8, 0, 0,  1, -1);
        set_row(7, 0, 0, 32'h0,         1, 0,  0, 1, 1, -1, -1);
        set_row(8, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, int'(TAIL_B2B));
        run_vec("b2b", 9);

        clear_vec();
        set_row(0, 1, 1, 32'h0403_0201, 1, 0,  0, 0, 1,  0, -1);
        set_row(1, 0, 0, 32'h0,         1, 0,  1, 0, 0,  1, -1);
        set_row(2, 0, 0, 32'h0,         0, 0,  0, 0, 0,  1, 32'h0000_0200);
        set_row(3, 1, 0, 32'h0909_0909, 0, 0,  0, 0, 0,  1, 32'h0000_0200);
        set_row(4, 0, 0, 32'h0,         0, 0,  0, 0, 0,  1, 32'h0000_0200);
        set_row(5, 0, 0, 32'h0,         1, 0,  2, 0, 0,  1, -1);
        set_row(6, 0, 0, 32'h0,         1, 0,  4, 0, 0,  1, -1);
        set_row(7, 0, 0, 32'h0,         1, 0,  8, 0, 0,  1, -1);
        set_row(8, 0, 0, 32'h0,         1, 0,  0, 1, 1, -1, -1);
        set_row(9, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        for (int c = 2; c <= 4; c++) mask_t[c] = 32'h0000_FF00;
        run_vec("stall", 10);

        clear_vec();
        set_row(0, 1, 0, 32'h0A0A_0A0A, 1, 0,  0, 0, 1,  0, -1);
        set_row(1, 0, 0, 32'h0,         1, 0,  1, 0, 1,  1, -1);
        set_row(2, 1, 1, 32'h0B0B_0B0B, 1, 0,  2, 0, 1,  1, -1);
        set_row(3, 0, 0, 32'h0,         1, 0,  5, 0, 0,  1, -1);
        set_row(4, 0, 0, 32'h0,         1, 0, 10, 0, 0,  1, -1);
        set_row(5, 0, 0, 32'h0,         1, 0,  4, 0, 0,  1, -1);
        set_row(6, 0, 0, 32'h0,         1, 0,  8, 0, 0,  1, -1);
        set_row(7, 0, 0, 32'h0,         1, 0,  0, 1, 1, -1, -1);
        set_row(8, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        run_vec("bubble", 9);

        clear_vec();
        set_row(0, 1, 1, 32'h0403_0201, 1, 0,  0, 0, 1,  0, -1);
        set_row(1, 0, 0, 32'h0,         1, 0,  1, 0, 0,  1, -1);
        set_row(2, 0, 0, 32'h0,         1, 1,  2, 0, 0,  1, -1);
        set_row(3, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, 0);
        set_row(4, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        set_row(5, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        set_row(6, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, -1);
        set_row(7, 0, 0, 32'h0,         1, 0,  0, 0, 1,  0, 0);
        run_vec("midrst", 8);

        load_single();
        run_vec("fresh", 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
